// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, control-bundle widths and bit positions.
package mips_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 5;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int M_BRANCH    = 0;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 2;
  localparam int EX_REGDST   = 0;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUOP_HI = 3;
  localparam int EX_ALUSRC   = 4;

  typedef struct packed {
    logic [WB_W-1:0] wb;
    logic [M_W-1:0]  m;
    logic [EX_W-1:0] ex;
  } ctrl_t;

  // Only these formats read rt as a source; I-type ALU ops and LW write it.
  function automatic logic uses_rt(input logic [5:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_SW) || (opc == OPC_BEQ);
  endfunction

endpackage

// File: rtl/id_ex_hazard_reg_if.sv
// ID-side inputs, control inputs and EX-side outputs of the ID/EX register.
interface id_ex_hazard_reg_if #(
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  import mips_pkg::*;

  logic             id_valid;
  logic [5:0]       id_opc;
  logic [WB_W-1:0]  id_wb;
  logic [M_W-1:0]   id_m;
  logic [EX_W-1:0]  id_ex;
  logic [W-1:0]     id_pc4;
  logic [W-1:0]     id_rd1;
  logic [W-1:0]     id_rd2;
  logic [W-1:0]     id_imm;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             flush;
  logic             hold;

  logic             ex_valid;
  logic [WB_W-1:0]  ex_wb;
  logic [M_W-1:0]   ex_m;
  logic [EX_W-1:0]  ex_ex;
  logic [W-1:0]     ex_pc4;
  logic [W-1:0]     ex_rd1;
  logic [W-1:0]     ex_rd2;
  logic [W-1:0]     ex_imm;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             stall;
  logic [CNT_W-1:0] bubble_cnt;

  modport master (
    output id_valid, id_opc, id_wb, id_m, id_ex, id_pc4, id_rd1, id_rd2, id_imm,
           id_rs, id_rt, id_rd, flush, hold,
    input  ex_valid, ex_wb, ex_m, ex_ex, ex_pc4, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_is_load, stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_opc, id_wb, id_m, id_ex, id_pc4, id_rd1, id_rd2, id_imm,
           id_rs, id_rt, id_rd, flush, hold,
    output ex_valid, ex_wb, ex_m, ex_ex, ex_pc4, ex_rd1, ex_rd2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_is_load, stall, bubble_cnt
  );

endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use check: the ID instruction reads the register a load in EX writes.
module load_use_detect
  import mips_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [5:0] id_opc,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = uses_rt(id_opc) && (ex_rt == id_rt);

  // $zero never carries a real dependency, so a load into r0 is ignored.
  assign hazard = ex_valid && ex_is_load && (ex_rt != 5'd0) && id_valid
                  && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and a
// saturating bubble counter; one cycle from ID capture to EX outputs.
module id_ex_hazard_reg
  import mips_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  id_ex_hazard_reg_if.slave  bus
);

  logic             valid_q;
  ctrl_t            ctrl_q;
  logic [W-1:0]     pc4_q;
  logic [W-1:0]     rd1_q;
  logic [W-1:0]     rd2_q;
  logic [W-1:0]     imm_q;
  logic [4:0]       rs_q;
  logic [4:0]       rt_q;
  logic [4:0]       rd_q;
  logic             is_load_q;
  logic [CNT_W-1:0] cnt_q;

  logic             hazard;
  logic             take_hazard;
  logic             clear;

  load_use_detect u_detect (
    .ex_valid   (valid_q),
    .ex_is_load (is_load_q),
    .ex_rt      (rt_q),
    .id_valid   (bus.id_valid),
    .id_opc     (bus.id_opc),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .hazard     (hazard)
  );

  // Flush and hold both outrank the hazard, so only a free-running hazard counts.
  assign take_hazard = !bus.flush && !bus.hold && hazard;
  assign clear       = rst || bus.flush || take_hazard;

  // Reset and a bubble are the same all-zero register image.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      pc4_q     <= '0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      is_load_q <= 1'b0;
    end else if (!bus.hold) begin
      valid_q   <= bus.id_valid;
      ctrl_q    <= '{wb: bus.id_wb, m: bus.id_m, ex: bus.id_ex};
      pc4_q     <= bus.id_pc4;
      rd1_q     <= bus.id_rd1;
      rd2_q     <= bus.id_rd2;
      imm_q     <= bus.id_imm;
      rs_q      <= bus.id_rs;
      rt_q      <= bus.id_rt;
      rd_q      <= bus.id_rd;
      is_load_q <= (bus.id_opc == OPC_LW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (take_hazard && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_wb      = ctrl_q.wb;
  assign bus.ex_m       = ctrl_q.m;
  assign bus.ex_ex      = ctrl_q.ex;
  assign bus.ex_pc4     = pc4_q;
  assign bus.ex_rd1     = rd1_q;
  assign bus.ex_rd2     = rd2_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_rs      = rs_q;
  assign bus.ex_rt      = rt_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_is_load = is_load_q;
  assign bus.bubble_cnt = cnt_q;

  // A squashed ID instruction needs no stall even if it would hazard.
  assign bus.stall = !bus.flush && (bus.hold || hazard);

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed bench for id_ex_hazard_reg; narrow counter so saturation is reached quickly.
module tb_id_ex_hazard_reg;

  localparam int W     = 32;
  localparam int CNT_W = 8;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_ex_hazard_reg_if #(.W(W), .CNT_W(CNT_W)) bus ();

  id_ex_hazard_reg #(.W(W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [5:0] opc, input logic [1:0] wb,
                        input logic [2:0] m, input logic [4:0] ex,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] pc4);
    bus.id_valid = v;
    bus.id_opc   = opc;
    bus.id_wb    = wb;
    bus.id_m     = m;
    bus.id_ex    = ex;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = rd;
    bus.id_pc4   = pc4;
    bus.id_rd1   = pc4 ^ 32'hA5A5_0000;
    bus.id_rd2   = pc4 ^ 32'h0000_5A5A;
    bus.id_imm   = pc4 + 32'd16;
    #1;
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    set_id(1'b1, LW, 2'b11, 3'b111, 5'b11111, 5'd7, 5'd9, 5'd3, 32'hDEAD_BEEF);

    // Reset with garbage on the ID side
    tick();
    tick();
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_wb", bus.ex_wb, 0);
    chk("rst_m", bus.ex_m, 0);
    chk("rst_ex", bus.ex_ex, 0);
    chk("rst_pc4", bus.ex_pc4, 0);
    chk("rst_rd1", bus.ex_rd1, 0);
    chk("rst_rt", bus.ex_rt, 0);
    chk("rst_is_load", bus.ex_is_load, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_cnt", bus.bubble_cnt, 0);

    // ADDI capture
    rst = 1'b0;
    set_id(1'b1, ADDI, 2'b11, 3'b000, 5'b00001, 5'd1, 5'd2, 5'd0, 32'h104);
    tick();
    chk("addi_valid", bus.ex_valid, 1);
    chk("addi_wb", bus.ex_wb, 2'b11);
    chk("addi_ex", bus.ex_ex, 5'b00001);
    chk("addi_is_load", bus.ex_is_load, 0);
    chk("addi_pc4", bus.ex_pc4, 32'h104);
    chk("addi_imm", bus.ex_imm, 32'h114);
    chk("addi_rd1", bus.ex_rd1, 32'hA5A5_0104);
    chk("addi_rt", bus.ex_rt, 5'd2);
    chk("addi_stall", bus.stall, 0);

    // LW r5, then R-type reading r5 through rs
    set_id(1'b1, LW, 2'b11, 3'b010, 5'b10000, 5'd2, 5'd5, 5'd0, 32'h108);
    tick();
    chk("lw_is_load", bus.ex_is_load, 1);
    chk("lw_m", bus.ex_m, 3'b010);
    set_id(1'b1, RTY, 2'b01, 3'b000, 5'b00101, 5'd5, 5'd6, 5'd7, 32'h10C);
    chk("lu_stall", bus.stall, 1);
    tick();
    chk("bub_valid", bus.ex_valid, 0);
    chk("bub_wb", bus.ex_wb, 0);
    chk("bub_rd1", bus.ex_rd1, 0);
    chk("bub_cnt", bus.bubble_cnt, 1);
    chk("bub_stall", bus.stall, 0);
    tick();
    chk("rty_valid", bus.ex_valid, 1);
    chk("rty_rs", bus.ex_rs, 5'd5);
    chk("rty_rd", bus.ex_rd, 5'd7);
    chk("rty_ex", bus.ex_ex, 5'b00101);
    chk("rty_cnt", bus.bubble_cnt, 1);

    // ADDI does not read rt; R-type does; flush overrides
    set_id(1'b1, LW, 2'b11, 3'b010, 5'b10000, 5'd2, 5'd5, 5'd0, 32'h110);
    tick();
    set_id(1'b1, ADDI, 2'b01, 3'b000, 5'b10000, 5'd3, 5'd5, 5'd0, 32'h114);
    chk("addi_rt_nostall", bus.stall, 0);
    set_id(1'b1, RTY, 2'b01, 3'b000, 5'b00101, 5'd3, 5'd5, 5'd8, 32'h114);
    chk("rty_rt_stall", bus.stall, 1);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", bus.stall, 0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_pc4", bus.ex_pc4, 0);
    chk("flush_cnt", bus.bubble_cnt, 1);

    // Load into r0 never hazards
    set_id(1'b1, LW, 2'b11, 3'b010, 5'b10000, 5'd1, 5'd0, 5'd0, 32'h118);
    tick();
    set_id(1'b1, RTY, 2'b01, 3'b000, 5'b00101, 5'd0, 5'd0, 5'd9, 32'h11C);
    chk("r0_stall", bus.stall, 0);
    tick();
    chk("r0_valid", bus.ex_valid, 1);
    chk("r0_cnt", bus.bubble_cnt, 1);

    // Hold with hazard: frozen, then bubble after release
    set_id(1'b1, LW, 2'b11, 3'b010, 5'b10000, 5'd1, 5'd5, 5'd0, 32'h200);
    tick();
    set_id(1'b1, RTY, 2'b01, 3'b000, 5'b00101, 5'd5, 5'd6, 5'd10, 32'h204);
    bus.hold = 1'b1;
    #1;
    chk("hold_stall", bus.stall, 1);
    tick();
    chk("hold_is_load", bus.ex_is_load, 1);
    chk("hold_pc4", bus.ex_pc4, 32'h200);
    chk("hold_cnt", bus.bubble_cnt, 1);
    bus.hold = 1'b0;
    #1;
    chk("rel_stall", bus.stall, 1);
    tick();
    chk("rel_valid", bus.ex_valid, 0);
    chk("rel_cnt", bus.bubble_cnt, 2);
    tick();
    chk("rel_pc4", bus.ex_pc4, 32'h204);

    // Reset in the middle of a stall
    set_id(1'b1, LW, 2'b11, 3'b010, 5'b10000, 5'd1, 5'd5, 5'd0, 32'h300);
    tick();
    set_id(1'b1, RTY, 2'b01, 3'b000, 5'b00101, 5'd5, 5'd6, 5'd10, 32'h304);
    chk("mid_stall", bus.stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_valid", bus.ex_valid, 0);
    chk("mid_cnt", bus.bubble_cnt, 0);
    chk("mid_stall_fall", bus.stall, 0);

    // Back-to-back dependent loads: one bubble per two cycles
    set_id(1'b1, LW, 2'b11, 3'b010, 5'b10000, 5'd5, 5'd5, 5'd0, 32'h400);
    for (int i = 0; i < 255; i++) begin
      tick();
      tick();
    end
    chk("sat_reach", bus.bubble_cnt, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      tick();
    end
    chk("sat_hold", bus.bubble_cnt, 8'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("sat_rst", bus.bubble_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
